// File: rtl/alu_imm_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_imm_exec_pkg
//   Shared types and constants for the OP-IMM execute stage.
//   - Op-code macros (`ADDI..`ANDI, `ALU_NOP). They are guarded so the copy in
//     processor_defines.sv and this one can coexist in one compilation unit.
//   - exec_state_t : execute-stage FSM states.
//   - shift_op_t   : shift flavour handed to the shifter.
//   - Helpers that classify an alu_control code as a shift.
// -----------------------------------------------------------------------------
`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`define ADDI    5'b00001
`define SLTI    5'b00010
`define SLTIU   5'b00011
`define XORI    5'b00100
`define ORI     5'b00101
`define ANDI    5'b00110
`define SLLI    5'b00111
`define SRLI    5'b01000
`define SRAI    5'b01001
`endif

package alu_imm_exec_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_op_t;

  function automatic logic is_shift_op(input logic [4:0] code);
    return (code == `SLLI) || (code == `SRLI) || (code == `SRAI);
  endfunction

  function automatic shift_op_t shift_op_of(input logic [4:0] code);
    case (code)
      `SLLI:   return SH_LL;
      `SRLI:   return SH_RL;
      default: return SH_RA;
    endcase
  endfunction

endpackage

// File: rtl/alu_imm_shifter.sv
// -----------------------------------------------------------------------------
// alu_imm_shifter
//   Shifter for SLLI/SRLI/SRAI.
//   SERIAL_SHIFT=1 : one bit per cycle. start_i loads the operand and shamt;
//                    done_o is high during the last shifting cycle, with
//                    result_o already showing the final value, so the caller
//                    can register it on the same edge the count hits zero.
//                    start_i must not be raised with shamt_i==0.
//   SERIAL_SHIFT=0 : combinational barrel shift; done_o follows start_i.
// Ports
//   clk, rst_n   : clock, synchronous active-low reset (clears busy/count)
//   flush        : abandons a shift in progress
//   start_i      : begin a shift (ignored while flush is high by the caller)
//   op_i         : shift flavour
//   shamt_i      : shift amount
//   operand_i    : value to shift
//   done_o       : result_o is final this cycle
//   result_o     : shifted value
// -----------------------------------------------------------------------------
module alu_imm_shifter
  import alu_imm_exec_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int SHAMT_W      = $clog2(XLEN),
  parameter int SERIAL_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start_i,
  input  shift_op_t          op_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [XLEN-1:0]    operand_i,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);

  function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v,
                                                input shift_op_t       op);
    case (op)
      SH_LL:   return {v[XLEN-2:0], 1'b0};
      SH_RL:   return {1'b0, v[XLEN-1:1]};
      default: return {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] barrel(input logic [XLEN-1:0]    v,
                                             input shift_op_t          op,
                                             input logic [SHAMT_W-1:0] n);
    logic signed [XLEN-1:0] vs;
    vs = v;
    case (op)
      SH_LL:   return v << n;
      SH_RL:   return v >> n;
      default: return vs >>> n;
    endcase
  endfunction

  if (SERIAL_SHIFT != 0) begin : g_serial
    logic [XLEN-1:0]    sh_q;
    shift_op_t          op_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               busy_q;

    // Control: the count is cleared by reset/flush so no stale shift resumes.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else if (flush) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= shamt_i;
      end else if (busy_q) begin
        cnt_q <= cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          busy_q <= 1'b0;
        end
      end
    end

    // Data: no reset needed, only meaningful while busy.
    always_ff @(posedge clk) begin
      if (start_i) begin
        sh_q <= operand_i;
        op_q <= op_i;
      end else if (busy_q) begin
        sh_q <= shift_one(sh_q, op_q);
      end
    end

    assign done_o   = busy_q && (cnt_q == SHAMT_W'(1));
    assign result_o = shift_one(sh_q, op_q);
  end else begin : g_barrel
    assign done_o   = start_i;
    assign result_o = barrel(operand_i, op_i, shamt_i);
  end

endmodule

// File: rtl/alu_imm_exec.sv
// -----------------------------------------------------------------------------
// alu_imm_exec
//   Execute stage for RV32I OP-IMM instructions. Accepts a decoded op, reads
//   rs1 from the register file in the accept cycle, computes the result
//   (optionally bit-serial for shifts) and offers it to writeback.
//   One op in flight at a time; in_ready is high only in IDLE, so every op
//   costs at least one bubble after its writeback handshake.
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   flush                 : kills any in-flight op (and a same-cycle accept)
//   in_valid / in_ready   : input handshake
//   rs1, rd, imm          : source index, destination index, I-immediate
//   alu_control           : op code (`ADDI..`ANDI, `SLLI/`SRLI/`SRAI, `ALU_NOP)
//   rf_raddr / rf_rdata   : combinational register-file read port
//   wb_valid / wb_ready   : output handshake
//   wb_we, wb_rd, wb_data : write-enable qualifier, destination, result
// -----------------------------------------------------------------------------
module alu_imm_exec
  import alu_imm_exec_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int SHAMT_W      = $clog2(XLEN),
  parameter int SERIAL_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rd,
  input  logic [11:0]     imm,
  input  logic [4:0]      alu_control,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  exec_state_t       state_q, state_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic              accept;
  logic              is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic              sh_start;
  logic              sh_done;
  logic [XLEN-1:0]   sh_result;

  logic signed [XLEN-1:0] a_s, i_s;
  logic [XLEN-1:0]        a_u, i_u;
  logic [XLEN-1:0]        alu_res;
  logic                   op_known;

  assign rf_raddr = rs1;
  assign in_ready = (state_q == IDLE);
  assign wb_valid = (state_q == DONE);
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

  // A flush in the accept cycle discards the op outright.
  assign accept   = in_valid && in_ready && !flush;
  assign is_shift = is_shift_op(alu_control);
  assign shamt    = imm[SHAMT_W-1:0];
  assign sh_start = accept && is_shift && (shamt != '0);

  assign a_s = rf_rdata;
  assign i_s = {{(XLEN-12){imm[11]}}, imm};
  assign a_u = rf_rdata;
  assign i_u = i_s;

  // Single-cycle result. For shifts in serial mode this path is only taken
  // when shamt==0, where the result is the operand itself.
  always_comb begin
    alu_res  = '0;
    op_known = 1'b1;
    case (alu_control)
      `ADDI:  alu_res = a_u + i_u;
      `SLTI:  alu_res = {{(XLEN-1){1'b0}}, (a_s < i_s)};
      `SLTIU: alu_res = {{(XLEN-1){1'b0}}, (a_u < i_u)};
      `XORI:  alu_res = a_u ^ i_u;
      `ORI:   alu_res = a_u | i_u;
      `ANDI:  alu_res = a_u & i_u;
      `SLLI, `SRLI, `SRAI:
        alu_res = (SERIAL_SHIFT != 0) ? a_u : sh_result;
      default: begin
        alu_res  = '0;
        op_known = 1'b0;
      end
    endcase
  end

  alu_imm_shifter #(
    .XLEN        (XLEN),
    .SHAMT_W     (SHAMT_W),
    .SERIAL_SHIFT(SERIAL_SHIFT)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .start_i  (sh_start),
    .op_i     (shift_op_of(alu_control)),
    .shamt_i  (shamt),
    .operand_i(rf_rdata),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

  // Next state and writeback fields. wb_rd/wb_we are captured at accept even
  // for serial shifts; only wb_data is filled in when the shift finishes.
  always_comb begin
    state_d   = state_q;
    wb_we_d   = wb_we_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wb_rd_d = rd;
          wb_we_d = op_known && (rd != 5'd0);
          if (sh_start && (SERIAL_SHIFT != 0)) begin
            state_d = SHIFT;
          end else begin
            state_d   = DONE;
            wb_data_d = alu_res;
          end
        end
      end
      SHIFT: begin
        if (sh_done) begin
          state_d   = DONE;
          wb_data_d = sh_result;
        end
      end
      DONE: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- state / writeback register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      state_q   <= state_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_alu_imm_exec.sv
module tb_alu_imm_exec;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_SLTI  = 5'b00010;
  localparam logic [4:0] OP_SLTIU = 5'b00011;
  localparam logic [4:0] OP_XORI  = 5'b00100;
  localparam logic [4:0] OP_ORI   = 5'b00101;
  localparam logic [4:0] OP_ANDI  = 5'b00110;
  localparam logic [4:0] OP_SLLI  = 5'b00111;
  localparam logic [4:0] OP_SRLI  = 5'b01000;
  localparam logic [4:0] OP_SRAI  = 5'b01001;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [11:0] imm;
  logic [4:0]  alu_control;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_total = 0;
  int n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_imm_exec #(
    .XLEN        (32),
    .SHAMT_W     (5),
    .SERIAL_SHIFT(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs1        (rs1),
    .rd         (rd),
    .imm        (imm),
    .alu_control(alu_control),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, return the number of edges from the accept edge until
  // wb_valid is seen (1 = visible right after the accept edge). Bounded.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                        input logic [11:0] im, input logic [4:0] r, output int lat);
    alu_control = op;
    rf_rdata    = a;
    imm         = im;
    rd          = r;
    rs1         = r ^ 5'd3;
    in_valid    = 1'b1;
    lat         = 0;
    do begin
      tick();
      in_valid = 1'b0;
      lat++;
    end while (!wb_valid && lat < 64);
  endtask

  task automatic expect_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [11:0] im, input logic [4:0] r,
                           input logic [31:0] exp_data, input logic exp_we, input int exp_lat);
    int lat;
    run_op(op, a, im, r, lat);
    check({tag, "/lat"}, lat, exp_lat);
    check({tag, "/data"}, wb_data, exp_data);
    check({tag, "/we"}, {31'd0, wb_we}, {31'd0, exp_we});
    check({tag, "/rd"}, {27'd0, wb_rd}, {27'd0, r});
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check({tag, "/idle"}, {30'd0, wb_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  stable;
    bit  seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    rs1 = 5'd0; rd = 5'd0; imm = 12'd0; alu_control = OP_NOP; rf_rdata = 32'd0;
    repeat (2) tick();
    check("rst/valid", {31'd0, wb_valid}, 32'd0);
    check("rst/we",    {31'd0, wb_we},    32'd0);
    check("rst/rd",    {27'd0, wb_rd},    32'd0);
    check("rst/data",  wb_data,           32'd0);
    check("rst/ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    rs1 = 5'd17;
    #1;
    check("raddr", {27'd0, rf_raddr}, 32'd17);

    // Single-cycle ops
    expect_op("addi_neg",  OP_ADDI,  32'h0000_0005, 12'hFFD, 5'd4,  32'd2,          1'b1, 1);
    expect_op("sltiu_fff", OP_SLTIU, 32'h0000_0005, 12'hFFF, 5'd3,  32'd1,          1'b1, 1);
    expect_op("slti_m1",   OP_SLTI,  32'h0000_0005, 12'hFFF, 5'd3,  32'd0,          1'b1, 1);
    expect_op("addi_x0",   OP_ADDI,  32'h0000_0005, 12'h001, 5'd0,  32'd6,          1'b0, 1);
    expect_op("addi_wrap", OP_ADDI,  32'hFFFF_FFFF, 12'h001, 5'd1,  32'd0,          1'b1, 1);
    expect_op("slti_neg",  OP_SLTI,  32'h8000_0000, 12'h000, 5'd2,  32'd1,          1'b1, 1);
    expect_op("sltiu_big", OP_SLTIU, 32'h8000_0000, 12'h000, 5'd2,  32'd0,          1'b1, 1);
    expect_op("xori",      OP_XORI,  32'h0F0F_0F0F, 12'h0FF, 5'd5,  32'h0F0F_0FF0, 1'b1, 1);
    expect_op("ori_sext",  OP_ORI,   32'h0000_0100, 12'h801, 5'd6,  32'hFFFF_F901, 1'b1, 1);
    expect_op("andi",      OP_ANDI,  32'h1234_5678, 12'h0F0, 5'd7,  32'h0000_0070, 1'b1, 1);
    expect_op("nop",       OP_NOP,   32'h0000_0005, 12'h001, 5'd5,  32'd0,          1'b0, 1);
    expect_op("bad_code",  5'b11111, 32'h0000_0005, 12'h001, 5'd5,  32'd0,          1'b0, 1);

    // Shifts
    expect_op("srai_4",    OP_SRAI,  32'h8000_0000, 12'h404, 5'd8,  32'hF800_0000, 1'b1, 5);
    expect_op("slli_0",    OP_SLLI,  32'hDEAD_BEEF, 12'h000, 5'd9,  32'hDEAD_BEEF, 1'b1, 1);
    expect_op("srli_31",   OP_SRLI,  32'hFFFF_FFFF, 12'h01F, 5'd10, 32'd1,          1'b1, 32);
    expect_op("slli_3",    OP_SLLI,  32'h0000_0001, 12'h003, 5'd11, 32'd8,          1'b1, 4);
    expect_op("srli_1",    OP_SRLI,  32'h8000_0000, 12'h001, 5'd12, 32'h4000_0000, 1'b1, 2);

    // Writeback stall: outputs frozen and no new accept while waiting
    run_op(OP_ADDI, 32'd100, 12'h00A, 5'd9, lat);
    check("stall/lat", lat, 1);
    alu_control = OP_XORI; rf_rdata = 32'h5555_5555; imm = 12'h0FF; rd = 5'd13;
    in_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (wb_valid !== 1'b1 || in_ready !== 1'b0 || wb_data !== 32'd110 ||
          wb_rd !== 5'd9 || wb_we !== 1'b1)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    check("stall/stable", {31'd0, stable}, 32'd1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("stall/release", {30'd0, wb_valid, in_ready}, 32'd1);
    tick();
    check("stall/no_sneak", {31'd0, wb_valid}, 32'd0);

    // Flush concurrent with accept discards the op
    alu_control = OP_ADDI; rf_rdata = 32'd1; imm = 12'h001; rd = 5'd3;
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_acc/ready", {30'd0, wb_valid, in_ready}, 32'd1);
    tick();
    check("flush_acc/valid", {31'd0, wb_valid}, 32'd0);

    // Flush at cycle 2 of a 20-cycle shift
    alu_control = OP_SRLI; rf_rdata = 32'hFFFF_FFFF; imm = 12'h014; rd = 5'd14;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("flush_sh/busy", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_sh/idle", {30'd0, wb_valid, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (wb_valid) seen = 1'b1;
    end
    check("flush_sh/no_wb", {31'd0, seen}, 32'd0);

    // Reset in the middle of a shift
    alu_control = OP_SLLI; rf_rdata = 32'd1; imm = 12'h014; rd = 5'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("rst_sh/valid", {31'd0, wb_valid}, 32'd0);
    check("rst_sh/we",    {31'd0, wb_we},    32'd0);
    check("rst_sh/rd",    {27'd0, wb_rd},    32'd0);
    check("rst_sh/data",  wb_data,           32'd0);
    check("rst_sh/ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (wb_valid) seen = 1'b1;
    end
    check("rst_sh/no_wb", {31'd0, seen}, 32'd0);
    expect_op("post_rst_srai", OP_SRAI, 32'h8000_0010, 12'h402, 5'd15, 32'hE000_0004, 1'b1, 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
